serial_frame_buffer: RTL and testbench

SERIAL_FRAME_BUFFER -- requirements
Module: serial_frame_buffer

---
 rtl/serial_frame_buffer.sv | 230 +++++++++++++++++++++++
 tb/tb_serial_frame_buffer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_buffer.sv
// serial_frame_buffer
//
// Captures a serial bit stream (MSB first, one bit per bit_tick) into a
// word buffer, then replays every stored word as a framed serial stream
// when a rising edge on send is seen.
//
// Frame on serial_out (idle high), one bit per bit_tick:
//   start (0), DATA_W data bits MSB first, [even parity], stop (1)
//
// Optional feature macro: SERIAL_FRAME_PARITY_EN
//   defined   -> frame carries an even-parity bit over the data bits
//                between the last data bit and the stop bit
//                (DATA_W+3 bits per frame)
//   undefined -> DATA_W+2 bits per frame, no parity logic
//
// Strobe semantics: bit_tick is a one-cycle qualifier. A capture bit is
// accepted, and serial_out advances, only in a cycle where bit_tick is
// high; there is no back-pressure. send is level-sampled each cycle and
// only its 0->1 transition is acted on.
//
// DEPTH must equal 2**ADDR_W. Memory contents are not reset.

module serial_frame_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              bit_tick,
  input  logic              serial_in,
  input  logic              send,
  output logic              serial_out,
  output logic              busy,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              overflow,
  output logic              done,
  output logic              state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Frame-bit index counter is wide enough for DATA_W up to 32 plus
  // start, parity and stop bits.
  localparam int FB_W = 6;

`ifdef SERIAL_FRAME_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 3;
`else
  localparam int FRAME_LEN = DATA_W + 2;
`endif

  // Frame index of the last data bit (start bit is index 0).
  localparam logic [FB_W-1:0] LAST_DATA_IDX = FB_W'(DATA_W);
  // Frame index of the stop bit.
  localparam logic [FB_W-1:0] STOP_IDX      = FB_W'(FRAME_LEN - 1);
  // Capture bit-counter value on the final bit of a word.
  localparam logic [FB_W-1:0] CAP_LAST      = FB_W'(DATA_W - 1);
  // word_count value meaning the buffer is full.
  localparam logic [ADDR_W:0] DEPTH_CNT     = (ADDR_W + 1)'(DEPTH);

  // Word storage, written during capture, read during replay.
  logic [DATA_W-1:0] mem [DEPTH];

  // FSM and datapath state.
  state_t            state_q;
  logic [DATA_W-1:0] cap_q;        // capture shift register
  logic [FB_W-1:0]   cap_cnt_q;    // bits captured into the current word
  logic [ADDR_W-1:0] wr_ptr_q;     // next memory slot to write
  logic [ADDR_W:0]   count_q;      // words stored, 0..DEPTH
  logic [ADDR_W:0]   rd_cnt_q;     // words fully replayed; low bits index mem
  logic [FB_W-1:0]   fbit_q;       // index of the next frame bit to drive
  logic [DATA_W-1:0] tx_q;         // data bits of the frame in flight
  logic              send_q;       // previous send level, for edge detect
  logic              serial_out_q;
  logic              busy_q;
  logic              overflow_q;
  logic              done_q;
`ifdef SERIAL_FRAME_PARITY_EN
  logic              parity_q;     // even parity of the frame in flight
`endif

  // Combinational helpers.
  logic              send_rise_d;
  logic [DATA_W-1:0] cap_word_d;
  logic              word_done_d;
  logic              full_d;
  logic              store_d;
  logic [ADDR_W-1:0] rd_idx_d;
  logic [DATA_W-1:0] rd_word_d;

  // Decode edges, word completion and the replay read word.
  always_comb begin
    send_rise_d = send & ~send_q;
    cap_word_d  = {cap_q[DATA_W-2:0], serial_in};
    full_d      = (count_q == DEPTH_CNT);
    word_done_d = (state_q == IDLE) && bit_tick && (cap_cnt_q == CAP_LAST);
    store_d     = word_done_d && !full_d;
    rd_idx_d    = rd_cnt_q[ADDR_W-1:0];
    rd_word_d   = mem[rd_idx_d];
  end

  // Store a completed word in the same cycle its last bit arrives.
  always_ff @(posedge sysclk) begin
    if (store_d) begin
      mem[wr_ptr_q] <= cap_word_d;
    end
  end

  // Capture/replay FSM with registered outputs.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cap_q        <= '0;
      cap_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      rd_cnt_q     <= '0;
      fbit_q       <= '0;
      tx_q         <= '0;
      send_q       <= 1'b0;
      serial_out_q <= 1'b1;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      send_q <= send;
      done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          // busy stays high through the done cycle, then drops here.
          busy_q <= 1'b0;

          if (bit_tick) begin
            cap_q <= cap_word_d;
            if (cap_cnt_q == CAP_LAST) begin
              cap_cnt_q <= '0;
              if (full_d) begin
                // Word is dropped; pointers and count are left alone.
                overflow_q <= 1'b1;
              end else begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                count_q  <= count_q + 1'b1;
              end
            end else begin
              cap_cnt_q <= cap_cnt_q + 1'b1;
            end
          end

          // A word finishing this cycle still bumps count_q above, so it
          // is part of the replay. Any partial word is abandoned.
          if (send_rise_d && (count_q != '0)) begin
            state_q   <= SEND;
            busy_q    <= 1'b1;
            rd_cnt_q  <= '0;
            cap_cnt_q <= '0;
            cap_q     <= '0;
            fbit_q    <= '0;
          end
        end

        SEND: begin
          // serial_in and send edges are not looked at in this state.
          if (bit_tick) begin
            if (rd_cnt_q == count_q) begin
              // Stop bit of the last word has been held for a full bit
              // period: finish the replay and empty the buffer.
              state_q      <= IDLE;
              done_q       <= 1'b1;
              overflow_q   <= 1'b0;
              count_q      <= '0;
              wr_ptr_q     <= '0;
              rd_cnt_q     <= '0;
              fbit_q       <= '0;
              serial_out_q <= 1'b1;
            end else if (fbit_q == '0) begin
              // Start bit; latch the word to be shifted out.
              serial_out_q <= 1'b0;
              tx_q         <= rd_word_d;
`ifdef SERIAL_FRAME_PARITY_EN
              parity_q     <= ^rd_word_d;
`endif
              fbit_q       <= fbit_q + 1'b1;
            end else if (fbit_q <= LAST_DATA_IDX) begin
              // Data bits, MSB first.
              serial_out_q <= tx_q[DATA_W-1];
              tx_q         <= {tx_q[DATA_W-2:0], 1'b0};
              fbit_q       <= fbit_q + 1'b1;
`ifdef SERIAL_FRAME_PARITY_EN
            end else if (fbit_q != STOP_IDX) begin
              // Even-parity bit.
              serial_out_q <= parity_q;
              fbit_q       <= fbit_q + 1'b1;
`endif
            end else begin
              // Stop bit; next tick starts the following frame (or ends).
              serial_out_q <= 1'b1;
              fbit_q       <= '0;
              rd_cnt_q     <= rd_cnt_q + 1'b1;
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Output mapping.
  always_comb begin
    serial_out = serial_out_q;
    busy       = busy_q;
    word_count = count_q;
    full       = full_d;
    overflow   = overflow_q;
    done       = done_q;
    state_dbg  = state_q;
  end

endmodule

// File: tb/tb_serial_frame_buffer.sv
// tb_serial_frame_buffer
//
// Directed bench for serial_frame_buffer with a word scoreboard: every
// word the bench captures (and expects to be stored) is pushed to exp_q,
// and every frame decoded from serial_out pops and compares one entry.
// Build with +define+SERIAL_FRAME_PARITY_EN to exercise the parity frame.

module tb_serial_frame_buffer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  // ---------------------------------------------------------------- clock/reset
  logic              sysclk    = 1'b0;
  logic              reset     = 1'b1;
  logic              bit_tick  = 1'b0;
  logic              serial_in = 1'b0;
  logic              send      = 1'b0;
  logic              serial_out;
  logic              busy;
  logic [ADDR_W:0]   word_count;
  logic              full;
  logic              overflow;
  logic              done;
  logic              state_dbg;

  always #5 sysclk = ~sysclk;

  serial_frame_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .bit_tick   (bit_tick),
    .serial_in  (serial_in),
    .send       (send),
    .serial_out (serial_out),
    .busy       (busy),
    .word_count (word_count),
    .full       (full),
    .overflow   (overflow),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [DATA_W-1:0] exp_q[$];
  int checks      = 0;
  int passed      = 0;
  int done_cnt    = 0;
  int model_count = 0;

  // Count done pulses, sampled away from the active edge.
  always @(negedge sysclk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------------------------------------------------------- drivers
  // One bit period: two idle cycles, then a one-cycle tick. Returns at the
  // negedge after the tick's clock edge, so outputs reflect that tick.
  task automatic do_tick(input logic b, input logic s);
    repeat (2) @(negedge sysclk);
    serial_in = b;
    send      = s;
    bit_tick  = 1'b1;
    @(negedge sysclk);
    bit_tick  = 1'b0;
    send      = 1'b0;
    serial_in = 1'($urandom_range(0, 1));
  endtask

  // Shift one word in MSB first; optionally raise send with the last bit.
  task automatic capture_word(input logic [DATA_W-1:0] w, input logic send_on_last);
    for (int i = DATA_W - 1; i >= 0; i--) begin
      do_tick(w[i], (i == 0) ? send_on_last : 1'b0);
    end
    if (model_count < DEPTH) begin
      exp_q.push_back(w);
      model_count++;
    end
  endtask

  task automatic send_pulse();
    @(negedge sysclk);
    send = 1'b1;
    @(negedge sysclk);
    send = 1'b0;
  endtask

  // Decode n frames from serial_out and compare against the scoreboard.
  task automatic replay_frames(input int n, input string tag);
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] exp_w;
    for (int f = 0; f < n; f++) begin
      do_tick(1'($urandom_range(0, 1)), 1'b0);
      chk({tag, "_start"}, serial_out, 1'b0);
      data = '0;
      for (int i = 0; i < DATA_W; i++) begin
        do_tick(1'($urandom_range(0, 1)), 1'b0);
        data = {data[DATA_W-2:0], serial_out};
      end
      exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      chk({tag, "_data"}, data, exp_w);
`ifdef SERIAL_FRAME_PARITY_EN
      do_tick(1'($urandom_range(0, 1)), 1'b0);
      chk({tag, "_parity"}, serial_out, ^exp_w);
`endif
      do_tick(1'($urandom_range(0, 1)), 1'b0);
      chk({tag, "_stop"}, serial_out, 1'b1);
      chk({tag, "_busy_in_frame"}, busy, 1'b1);
    end
  endtask

  // One more bit period after the last stop bit ends the replay.
  task automatic finish_replay(input string tag, input int done_before);
    do_tick(1'($urandom_range(0, 1)), 1'b0);
    chk({tag, "_done_hi"}, done, 1'b1);
    chk({tag, "_busy_done_cycle"}, busy, 1'b1);
    chk({tag, "_count_cleared"}, word_count, '0);
    chk({tag, "_idle_line"}, serial_out, 1'b1);
    @(negedge sysclk);
    chk({tag, "_done_lo"}, done, 1'b0);
    chk({tag, "_busy_lo"}, busy, 1'b0);
    @(negedge sysclk);
    chk({tag, "_done_once"}, done_cnt - done_before, 1);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
    model_count = 0;
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin : main
    int d0;
    logic [DATA_W-1:0] w;

    // Reset state.
    repeat (3) @(negedge sysclk);
    chk("rst_serial_out", serial_out, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_word_count", word_count, '0);
    chk("rst_state", state_dbg, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge sysclk);

    // Send with an empty buffer is ignored.
    d0 = done_cnt;
    send_pulse();
    for (int i = 0; i < 3; i++) begin
      chk("empty_send_busy", busy, 1'b0);
      chk("empty_send_line", serial_out, 1'b1);
      @(negedge sysclk);
    end
    chk("empty_send_no_done", done_cnt - d0, 0);

    // Three words, then replay.
    capture_word(16'hA5A5, 1'b0);
    capture_word(16'h1234, 1'b0);
    capture_word(16'hFFFF, 1'b0);
    chk("three_count", word_count, 3);
    chk("three_full", full, 1'b0);
    d0 = done_cnt;
    send_pulse();
    chk("three_busy_entry", busy, 1'b1);
    replay_frames(3, "three");
    finish_replay("three", d0);

    // Single word 0x0001, with a partial word abandoned at send.
    capture_word(16'h0001, 1'b0);
    for (int i = 0; i < 5; i++) do_tick(1'b1, 1'b0);
    chk("partial_count", word_count, 1);
    d0 = done_cnt;
    send_pulse();
    replay_frames(1, "one");
    finish_replay("one", d0);

    // Word completing on the send edge joins the replay; the abandoned
    // partial bits above must not have shifted this capture.
    capture_word(16'h1234, 1'b0);
    d0 = done_cnt;
    capture_word(16'h00FF, 1'b1);
    chk("coincide_busy", busy, 1'b1);
    chk("coincide_count", word_count, 2);
    replay_frames(2, "coincide");
    finish_replay("coincide", d0);

    // Fill, overflow by one, replay only the stored words.
    for (int i = 0; i < DEPTH; i++) begin
      w = DATA_W'($urandom_range(0, 16'hFFFF));
      capture_word(w, 1'b0);
    end
    chk("fill_full", full, 1'b1);
    chk("fill_overflow_clear", overflow, 1'b0);
    chk("fill_count", word_count, DEPTH);
    capture_word(16'hDEAD, 1'b0);
    chk("ovf_overflow", overflow, 1'b1);
    chk("ovf_count", word_count, DEPTH);
    chk("ovf_full", full, 1'b1);
    d0 = done_cnt;
    send_pulse();
    // A second send edge while replaying must not restart anything.
    send_pulse();
    chk("ovf_busy", busy, 1'b1);
    replay_frames(DEPTH, "ovf");
    finish_replay("ovf", d0);
    chk("ovf_cleared_at_done", overflow, 1'b0);
    chk("ovf_full_cleared", full, 1'b0);

    // Reset during the data bits of frame 1 aborts the replay.
    capture_word(16'hA5A5, 1'b0);
    capture_word(16'h00F0, 1'b0);
    d0 = done_cnt;
    send_pulse();
    replay_frames(1, "abort");
    do_tick(1'b0, 1'b0);
    chk("abort_frame1_start", serial_out, 1'b0);
    do_tick(1'b0, 1'b0);
    do_tick(1'b0, 1'b0);
    chk("abort_frame1_data", serial_out, 1'b0);
    reset = 1'b1;
    @(negedge sysclk);
    chk("abort_line_high", serial_out, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_count", word_count, '0);
    reset = 1'b0;
    exp_q.delete();
    model_count = 0;
    repeat (3) @(negedge sysclk);
    chk("abort_no_done", done_cnt - d0, 0);

    // Buffer is usable again after the abort.
    capture_word(16'h8001, 1'b0);
    chk("post_abort_count", word_count, 1);
    d0 = done_cnt;
    send_pulse();
    replay_frames(1, "post_abort");
    finish_replay("post_abort", d0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
